// File: rtl/menu_sprite_renderer.sv
// rtl/menu_sprite_renderer.sv - menu sprite pixel stage: window test, frame ROM address, palette lookup, sync delay
// Optional feature macro: MENU_ANIM_EN (alternate menu image 0/1 every FRAMES_PER_TOGGLE frames).
// Palette contents (32 x 12-bit {R,G,B}) come from the PALETTE parameter; index 0 is transparent.
// Ports:
//   pixel_clk                  pixel clock, all state on the rising edge
//   reset_n                    synchronous active-low reset
//   menu_active                1 = draw the menu, 0 = output black
//   drawX, drawY               current pixel column/row from the VGA timing generator
//   hs_in, vs_in               syncs from the timing generator, active-low
//   blank_in                   1 = active video
//   rom_addr                   registered frame ROM read address
//   rom_data0, rom_data1       palette indices from the combinational ROMs of images 0 and 1
//   red, green, blue           registered 4:4:4 RGB
//   hs_out, vs_out, blank_out  timing inputs delayed by 3 cycles
//   img_sel                    image currently shown
module menu_sprite_renderer #(
  parameter int          IMG_W             = 450,
  parameter int          IMG_H             = 370,
  parameter int          X0                = 95,
  parameter int          Y0                = 55,
  parameter logic [11:0] BG_COLOR          = 12'h000,
  parameter int          FRAMES_PER_TOGGLE = 30,
  parameter logic [11:0] PALETTE [32]      = '{
    12'h000, 12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
    12'h888, 12'h444, 12'hCCC, 12'h800, 12'h080, 12'h008, 12'h880, 12'h088,
    12'h808, 12'hF80, 12'h8F0, 12'h08F, 12'hF08, 12'h0F8, 12'h80F, 12'hFA5,
    12'h5AF, 12'hA5F, 12'h333, 12'h666, 12'h999, 12'hBBB, 12'hDDD, 12'hEEE
  }
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        menu_active,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_in,
  output logic [18:0] rom_addr,
  input  logic [4:0]  rom_data0,
  input  logic [4:0]  rom_data1,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hs_out,
  output logic        vs_out,
  output logic        blank_out,
  output logic        img_sel
);

  // Stage 1: window test and sprite-relative coordinates
  logic       in_win1_q, in_win1_d;
  logic [8:0] rx1_q, rx1_d;
  logic [8:0] ry1_q, ry1_d;
  logic       hs1_q, hs1_d, vs1_q, vs1_d, blank1_q, blank1_d, act1_q, act1_d;

  // Stage 2: ROM address
  logic [18:0] rom_addr_q, rom_addr_d;
  logic        in_win2_q, in_win2_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d, blank2_q, blank2_d, act2_q, act2_d;

  // Stage 3: colour
  logic [11:0] rgb_q, rgb_d;
  logic        hs3_q, hs3_d, vs3_q, vs3_d, blank3_q, blank3_d;

  logic [4:0]  idx;

`ifdef MENU_ANIM_EN
  localparam int CNT_W = (FRAMES_PER_TOGGLE > 1) ? $clog2(FRAMES_PER_TOGGLE) : 1;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             img_sel_q, img_sel_d;
  logic             vs_fall;
`else
  localparam int unused_frames_per_toggle = FRAMES_PER_TOGGLE;
  logic unused_rom_data1;
  assign unused_rom_data1 = ^rom_data1;
`endif

  always_comb begin
    // Stage 1
    in_win1_d = menu_active
             && (int'(drawX) >= X0) && (int'(drawX) < X0 + IMG_W)
             && (int'(drawY) >= Y0) && (int'(drawY) < Y0 + IMG_H);
    rx1_d    = 9'(drawX - 10'(X0));
    ry1_d    = 9'(drawY - 10'(Y0));
    hs1_d    = hs_in;
    vs1_d    = vs_in;
    blank1_d = blank_in;
    act1_d   = menu_active;

    // Stage 2: full-width multiply so the last row (ry=369) does not wrap
    rom_addr_d = in_win1_q ? (19'(ry1_q) * 19'(IMG_W) + 19'(rx1_q)) : 19'd0;
    in_win2_d  = in_win1_q;
    hs2_d      = hs1_q;
    vs2_d      = vs1_q;
    blank2_d   = blank1_q;
    act2_d     = act1_q;

    // Stage 3: ROM data belongs to the address registered in stage 2
`ifdef MENU_ANIM_EN
    idx = img_sel_q ? rom_data1 : rom_data0;
`else
    idx = rom_data0;
`endif
    if (!blank2_q || !act2_q) begin
      rgb_d = 12'h000;
    end else if (!in_win2_q || idx == 5'd0) begin
      rgb_d = BG_COLOR;
    end else begin
      rgb_d = PALETTE[idx];
    end
    hs3_d    = hs2_q;
    vs3_d    = vs2_q;
    blank3_d = blank2_q;

`ifdef MENU_ANIM_EN
    // vs1_q holds the previous vs_in sample, so this flags the first low cycle of vsync
    vs_fall     = vs1_q && !vs_in;
    frame_cnt_d = frame_cnt_q;
    img_sel_d   = img_sel_q;
    if (vs_fall && menu_active) begin
      if (frame_cnt_q == CNT_W'(FRAMES_PER_TOGGLE - 1)) begin
        frame_cnt_d = '0;
        img_sel_d   = !img_sel_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      in_win1_q  <= 1'b0;
      rx1_q      <= '0;
      ry1_q      <= '0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      blank1_q   <= 1'b0;
      act1_q     <= 1'b0;
      rom_addr_q <= '0;
      in_win2_q  <= 1'b0;
      hs2_q      <= 1'b1;
      vs2_q      <= 1'b1;
      blank2_q   <= 1'b0;
      act2_q     <= 1'b0;
      rgb_q      <= '0;
      hs3_q      <= 1'b1;
      vs3_q      <= 1'b1;
      blank3_q   <= 1'b0;
`ifdef MENU_ANIM_EN
      frame_cnt_q <= '0;
      img_sel_q   <= 1'b0;
`endif
    end else begin
      in_win1_q  <= in_win1_d;
      rx1_q      <= rx1_d;
      ry1_q      <= ry1_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      blank1_q   <= blank1_d;
      act1_q     <= act1_d;
      rom_addr_q <= rom_addr_d;
      in_win2_q  <= in_win2_d;
      hs2_q      <= hs2_d;
      vs2_q      <= vs2_d;
      blank2_q   <= blank2_d;
      act2_q     <= act2_d;
      rgb_q      <= rgb_d;
      hs3_q      <= hs3_d;
      vs3_q      <= vs3_d;
      blank3_q   <= blank3_d;
`ifdef MENU_ANIM_EN
      frame_cnt_q <= frame_cnt_d;
      img_sel_q   <= img_sel_d;
`endif
    end
  end

  assign rom_addr  = rom_addr_q;
  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];
  assign hs_out    = hs3_q;
  assign vs_out    = vs3_q;
  assign blank_out = blank3_q;
`ifdef MENU_ANIM_EN
  assign img_sel   = img_sel_q;
`else
  assign img_sel   = 1'b0;
`endif

endmodule
